// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//   Instruction fetch stage between the PC update unit and decode. It issues
//   in-order fetches to instruction memory (req/gnt/rvalid), tags each returned
//   instruction with its PC, and buffers results in a 2-entry output queue that
//   feeds decode over a valid/ready handshake. A redirect (flush) discards all
//   buffered and in-flight fetches; responses still owed by memory are drained
//   and dropped before fetching resumes.
//
// Ports
//   clk          clock, all state on rising edge
//   reset_n      asynchronous active-low reset
//   pc_in        current PC from the PC update unit
//   pc_advance   PC write enable back to the PC unit (request accepted)
//   flush        redirect; pc_in holds the target on the following cycle
//   imem_req     fetch request            imem_addr   fetch address (= pc_in)
//   imem_gnt     memory accepts request   imem_rvalid in-order response valid
//   imem_rdata   response instruction
//   id_valid     instruction available    id_ready    decode accepts
//   id_pc        PC of head entry         id_instr    instruction of head entry
//   id_fault     head entry is a misaligned-PC fault (id_instr = 0)
// -----------------------------------------------------------------------------

// Protocol checker: a response with nothing outstanding is a memory error.
module instr_fetch_stage_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          reset_n,
    input logic          imem_rvalid,
    input logic [CW-1:0] outstanding
);
    a_rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> (outstanding != {CW{1'b0}})
    );
endmodule

module instr_fetch_stage #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_advance,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr,
    output logic            id_fault
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int UW = CW + 2;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   out_q, out_d;
    logic            stall_q, stall_d;

    logic [XLEN-1:0] tag_mem_q [DEPTH];
    logic [PW-1:0]   tag_wp_q, tag_rp_q;

    logic            v0_q, v0_d, v1_q, v1_d;
    logic [XLEN-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [ILEN-1:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic            flt0_q, flt0_d, flt1_q, flt1_d;

    logic [1:0]      oq_cnt_s;
    logic [UW-1:0]   used_s;
    logic            pop_s, credit_s, aligned_s, rsp_ok_s, can_issue_s;
    logic            accept_s, rsp_push_s, fault_push_s, push_s;
    logic [XLEN-1:0] push_pc_s;
    logic [ILEN-1:0] push_ins_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Credit and issue qualification. The slot freed by this cycle's decode
    // pop counts as available, so a k=1 memory streams one fetch per cycle;
    // occupancy after the edge still never exceeds DEPTH.
    always_comb begin
        oq_cnt_s    = {1'b0, v0_q} + {1'b0, v1_q};
        pop_s       = v0_q & id_ready;
        used_s      = UW'(out_q) + UW'(oq_cnt_s) - UW'(pop_s);
        credit_s    = (used_s < UW'(DEPTH));
        aligned_s   = (pc_in[1:0] == 2'b00);
        rsp_ok_s    = imem_rvalid & (out_q != {CW{1'b0}});
        can_issue_s = reset_n & (state_q == ST_RUN) & credit_s & ~flush & ~stall_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave RUN on a flush that leaves responses owed,
    // return once every owed response has been dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush && (out_d != {CW{1'b0}})) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (out_d == {CW{1'b0}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs: memory request side is combinational from pc_in/state/credit.
    always_comb begin
        imem_req   = can_issue_s & aligned_s;
        pc_advance = imem_req & imem_gnt;
        imem_addr  = pc_in;
    end

    // Datapath control: accepted requests, responses kept, fault entries.
    always_comb begin
        accept_s     = pc_advance;
        rsp_push_s   = (state_q == ST_RUN) & rsp_ok_s & ~flush;
        // A misaligned PC is reported only once older fetches have returned,
        // so the fault entry lands behind them in program order.
        fault_push_s = can_issue_s & ~aligned_s & (out_q == {CW{1'b0}});
        push_s       = rsp_push_s | fault_push_s;
        out_d        = out_q + CW'(accept_s) - CW'(rsp_ok_s);
        if (fault_push_s) begin
            push_pc_s  = pc_in;
            push_ins_s = {ILEN{1'b0}};
        end else begin
            push_pc_s  = tag_mem_q[tag_rp_q];
            push_ins_s = imem_rdata;
        end
        if (flush) begin
            stall_d = 1'b0;
        end else if (fault_push_s) begin
            stall_d = 1'b1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Outstanding-request counter and misaligned-stall latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q   <= {CW{1'b0}};
            stall_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            stall_q <= stall_d;
        end
    end

    // PC tag queue. Cleared on flush: responses owed afterwards are dropped
    // in DRAIN without consulting it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i] <= {XLEN{1'b0}};
            end
            tag_wp_q <= {PW{1'b0}};
            tag_rp_q <= {PW{1'b0}};
        end else if (flush) begin
            tag_wp_q <= {PW{1'b0}};
            tag_rp_q <= {PW{1'b0}};
        end else begin
            if (accept_s) begin
                tag_mem_q[tag_wp_q] <= pc_in;
                tag_wp_q            <= ptr_inc(tag_wp_q);
            end
            if (rsp_push_s) begin
                tag_rp_q <= ptr_inc(tag_rp_q);
            end
        end
    end

    // Output queue next state: entry 0 is always the head.
    always_comb begin
        v0_d = v0_q;   v1_d = v1_q;
        pc0_d = pc0_q; pc1_d = pc1_q;
        ins0_d = ins0_q; ins1_d = ins1_q;
        flt0_d = flt0_q; flt1_d = flt1_q;
        if (flush) begin
            v0_d = 1'b0;
            v1_d = 1'b0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (!v0_q) begin
                        v0_d = 1'b1; pc0_d = push_pc_s; ins0_d = push_ins_s; flt0_d = fault_push_s;
                    end else begin
                        v1_d = 1'b1; pc1_d = push_pc_s; ins1_d = push_ins_s; flt1_d = fault_push_s;
                    end
                end
                2'b01: begin
                    v0_d = v1_q; pc0_d = pc1_q; ins0_d = ins1_q; flt0_d = flt1_q;
                    v1_d = 1'b0;
                end
                2'b11: begin
                    if (v1_q) begin
                        pc0_d = pc1_q; ins0_d = ins1_q; flt0_d = flt1_q;
                        pc1_d = push_pc_s; ins1_d = push_ins_s; flt1_d = fault_push_s;
                    end else begin
                        pc0_d = push_pc_s; ins0_d = push_ins_s; flt0_d = fault_push_s;
                    end
                end
                default: begin
                    v0_d = v0_q;
                end
            endcase
        end
    end

    // Output queue registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v0_q <= 1'b0;            v1_q <= 1'b0;
            pc0_q <= {XLEN{1'b0}};   pc1_q <= {XLEN{1'b0}};
            ins0_q <= {ILEN{1'b0}};  ins1_q <= {ILEN{1'b0}};
            flt0_q <= 1'b0;          flt1_q <= 1'b0;
        end else begin
            v0_q <= v0_d;     v1_q <= v1_d;
            pc0_q <= pc0_d;   pc1_q <= pc1_d;
            ins0_q <= ins0_d; ins1_q <= ins1_d;
            flt0_q <= flt0_d; flt1_q <= flt1_d;
        end
    end

    assign id_valid = v0_q;
    assign id_pc    = pc0_q;
    assign id_instr = ins0_q;
    assign id_fault = flt0_q;

    instr_fetch_stage_chk #(.CW(CW)) u_chk (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_rvalid (imem_rvalid),
        .outstanding (out_q)
    );

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;
    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [XLEN-1:0] pc_in;
    logic            pc_advance;
    logic            flush;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [ILEN-1:0] imem_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [ILEN-1:0] id_instr;
    logic            id_fault;

    always #5 clk = ~clk;

    instr_fetch_stage #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_in       (pc_in),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_fault    (id_fault)
    );

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            fault;
    } exp_t;

    // Scoreboard: instructions decode must see, in order.
    exp_t            exp_q[$];
    // Memory model: PCs of accepted requests still owed a response.
    logic [XLEN-1:0] mem_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int p_gnt = 0, p_rv = 0, p_rdy = 0, p_flush = 0;

    logic            adv = 1'b0;
    logic            was_flush = 1'b0;
    logic            drain_pending = 1'b0;
    logic            force_flush = 1'b0;
    logic [XLEN-1:0] force_tgt = 64'h0;
    logic [XLEN-1:0] target = 64'h0;
    logic [XLEN-1:0] saved_addr;

    function automatic logic [ILEN-1:0] mem_word(input logic [XLEN-1:0] a);
        return a[31:0] + 32'h0000_0100;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy, input int fl);
        p_gnt = g; p_rv = rv; p_rdy = rdy; p_flush = fl;
    endtask

    // One clock cycle: PC unit + memory + decode stimulus, then cycle checks.
    task automatic drive_cycle();
        exp_t e;
        @(posedge clk);
        #1;
        if (adv) begin
            pc_in = pc_in + 64'd4;
            adv   = 1'b0;
        end
        if (flush) begin
            flush = 1'b0;
            pc_in = target;
            if (target[1:0] != 2'b00) begin
                e.pc = target; e.instr = 32'h0; e.fault = 1'b1;
                exp_q.push_back(e);
            end
        end else if (force_flush || ($urandom_range(99) < p_flush)) begin
            flush = 1'b1;
            if (force_flush) begin
                target = force_tgt;
            end else begin
                target = 64'($urandom_range(32'hFFF)) << 2;
                if ($urandom_range(3) == 0) target = target + 64'($urandom_range(3, 1));
            end
            force_flush = 1'b0;
        end
        imem_gnt    = ($urandom_range(99) < p_gnt);
        imem_rvalid = (mem_q.size() > 0) && ($urandom_range(99) < p_rv);
        imem_rdata  = imem_rvalid ? mem_word(mem_q[0]) : 32'hDEAD_BEEF;
        id_ready    = ($urandom_range(99) < p_rdy);
        @(negedge clk);
        chk("pc_advance", pc_advance, imem_req & imem_gnt);
        if (imem_req) chk("imem_addr", imem_addr, pc_in);
        if (flush || (pc_in[1:0] != 2'b00)) chk("req_blocked", imem_req, 1'b0);
        if (was_flush) chk("flush_clears_valid", id_valid, 1'b0);
        if (drain_pending) chk("drain_no_req", imem_req, 1'b0);
        if (imem_rvalid) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) begin
            mem_q.push_back(pc_in);
            e.pc = pc_in; e.instr = mem_word(pc_in); e.fault = 1'b0;
            exp_q.push_back(e);
            adv = 1'b1;
            acc_cnt++;
        end
        chk("outstanding_cap", (mem_q.size() <= DEPTH), 1'b1);
        if (flush) begin
            exp_q.delete();
            drain_pending = (mem_q.size() > 0);
        end else if (mem_q.size() == 0) begin
            drain_pending = 1'b0;
        end
        was_flush = flush;
    endtask

    // Monitor: every decode handshake is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && id_valid && id_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %0h instr %0h, expected none", id_pc, id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", id_pc, e.pc);
                    chk("id_instr", id_instr, e.instr);
                    chk("id_fault", id_fault, e.fault);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; pc_in = 64'h0; flush = 1'b0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_imem_req", imem_req, 1'b0);
        chk("rst_pc_advance", pc_advance, 1'b0);
        chk("rst_id_valid", id_valid, 1'b0);
        chk("rst_id_pc", id_pc, 64'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_fault", id_fault, 1'b0);
        reset_n = 1'b1;

        // Sequential fetch, 1-cycle memory, decode always ready.
        set_knobs(100, 100, 100, 0);
        acc_cnt = 0;
        drive_cycle(); chk("latency_c0", id_valid, 1'b0);
        drive_cycle(); chk("latency_c1", id_valid, 1'b0);
        drive_cycle(); chk("latency_c2", id_valid, 1'b1);
        repeat (7) drive_cycle();
        chk("throughput", acc_cnt, 10);

        // Backpressure: credit runs out, nothing is lost.
        set_knobs(100, 100, 0, 0);
        repeat (5) drive_cycle();
        chk("credit_exhausted", imem_req, 1'b0);
        set_knobs(100, 100, 100, 0);
        repeat (6) drive_cycle();

        // Grant stall: address holds, PC does not advance.
        set_knobs(0, 100, 100, 0);
        drive_cycle();
        saved_addr = imem_addr;
        repeat (2) drive_cycle();
        chk("gnt_stall_addr", imem_addr, saved_addr);
        set_knobs(100, 100, 100, 0);
        repeat (3) drive_cycle();

        // Flush with two responses owed; next delivered PC is the target.
        set_knobs(100, 0, 100, 0);
        repeat (3) drive_cycle();
        chk("two_outstanding", mem_q.size(), 2);
        force_flush = 1'b1; force_tgt = 64'h40;
        repeat (2) drive_cycle();
        set_knobs(100, 100, 100, 0);
        repeat (8) drive_cycle();

        // Flush in the same cycle as a response, queue occupied.
        repeat (3) drive_cycle();
        set_knobs(100, 100, 0, 0);
        force_flush = 1'b1; force_tgt = 64'h200;
        drive_cycle();
        set_knobs(100, 100, 100, 0);
        repeat (4) drive_cycle();

        // Misaligned target: one fault entry, no fetches until the next flush.
        force_flush = 1'b1; force_tgt = 64'h6;
        acc_cnt = 0;
        repeat (8) drive_cycle();
        chk("misaligned_no_fetch", acc_cnt, 0);
        chk("fault_delivered", exp_q.size(), 0);
        force_flush = 1'b1; force_tgt = 64'h8;
        repeat (5) drive_cycle();
        chk("resume_after_flush", (acc_cnt > 0), 1'b1);

        // Randomized traffic.
        set_knobs(80, 70, 70, 3);   repeat (500) drive_cycle();
        set_knobs(50, 40, 30, 5);   repeat (500) drive_cycle();
        set_knobs(100, 100, 100, 2); repeat (500) drive_cycle();
        set_knobs(30, 90, 90, 8);   repeat (500) drive_cycle();

        // Reset in the middle of traffic; memory is reset with it.
        reset_n = 1'b0;
        flush = 1'b0; imem_rvalid = 1'b0; adv = 1'b0;
        was_flush = 1'b0; drain_pending = 1'b0;
        mem_q.delete(); exp_q.delete();
        pc_in = 64'h1000;
        #1;
        chk("midrst_id_valid", id_valid, 1'b0);
        chk("midrst_imem_req", imem_req, 1'b0);
        chk("midrst_id_pc", id_pc, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        set_knobs(90, 60, 60, 4); repeat (300) drive_cycle();

        // Drain: stop granting, let everything owed come back and be consumed.
        set_knobs(0, 100, 100, 0);
        repeat (30) drive_cycle();
        chk("drained_scoreboard", exp_q.size(), 0);
        chk("drained_memory", mem_q.size(), 0);
        chk("drained_id_valid", id_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
